// File: rtl/pwm_duty_decoder_if.sv
// PWM duty decoder signal bundle: the sampled PWM input plus the
// measurement results. The slave modport is the decoder's view, the
// master modport is the view of whoever drives pwm_in and consumes results.
interface pwm_duty_decoder_if #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 4
);
  logic              pwm_in;
  logic [DUTY_W-1:0] duty;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  period_cnt;
  logic              valid;
  logic              timeout;
  logic              overrun;

  modport master (
    output pwm_in,
    input  duty, high_cnt, period_cnt, valid, timeout, overrun
  );

  modport slave (
    input  pwm_in,
    output duty, high_cnt, period_cnt, valid, timeout, overrun
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures high time and period (rising edge to rising
// edge) of an asynchronous PWM input and recovers
// duty = floor(high * 2^DUTY_W / period) with a restoring divider.
// Stuck inputs are reported through an edge-idle timeout.
// Optional: define PWM_DEC_GLITCH_FILTER_EN to debounce the synchronized
// input (a level must hold 3 cycles before it is accepted).
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int DUTY_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  pwm_duty_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
  localparam int               STEP_W  = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [DUTY_W-1:0] sat_quo(input logic sat, input logic [DUTY_W-1:0] q);
    return sat ? {DUTY_W{1'b1}} : q;
  endfunction

  // ---------------------------------------------------------------- input path
  logic s1, s2;
  logic lvl, rise, fall;

  // Two-flop synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic       f;
  logic [1:0] run_cnt;
  logic       filt_chg;

  // Accept a new level on the third consecutive cycle s2 disagrees with f.
  assign filt_chg = (s2 != f) && (run_cnt == 2'd2);

  // Filtered level and run length of the disagreeing s2 value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f       <= 1'b0;
      run_cnt <= 2'd0;
    end else if (s2 == f) begin
      run_cnt <= 2'd0;
    end else if (filt_chg) begin
      f       <= s2;
      run_cnt <= 2'd0;
    end else begin
      run_cnt <= run_cnt + 2'd1;
    end
  end

  assign lvl  = filt_chg ? s2 : f;
  assign rise = filt_chg & s2;
  assign fall = filt_chg & ~s2;
`else
  logic s3;

  // History flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s3 <= 1'b0;
    else     s3 <= s2;
  end

  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
`endif

  // ---------------------------------------------------------------- timeout
  logic [CNT_W-1:0] idle_cnt;
  logic             timeout_q;
  logic             to_evt;

  // Fires once on the TIMEOUT-th consecutive cycle without an edge.
  assign to_evt = ~(rise | fall) & ~timeout_q & (idle_cnt == TO_LIM - CNT_W'(1));

  // Cycles since the last edge, held once the limit is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   idle_cnt <= '0;
    else if (rise | fall)      idle_cnt <= '0;
    else if (idle_cnt != TO_LIM) idle_cnt <= idle_cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------- measurement FSM
  state_t           state, state_nx;
  logic [CNT_W-1:0] hc, hc_nx, pc, pc_nx;
  logic             period_done;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hc    <= '0;
      pc    <= '0;
    end else begin
      state <= state_nx;
      hc    <= hc_nx;
      pc    <= pc_nx;
    end
  end

  // Next state and counter updates; a timeout overrides everything.
  always_comb begin
    state_nx    = state;
    hc_nx       = hc;
    pc_nx       = pc;
    period_done = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HIGH;
          hc_nx    = CNT_W'(1);
          pc_nx    = CNT_W'(1);
        end
      end
      HIGH: begin
        if (fall) begin
          state_nx = LOW;
          pc_nx    = sat_inc(pc);
        end else begin
          hc_nx = sat_inc(hc);
          pc_nx = sat_inc(pc);
        end
      end
      LOW: begin
        if (rise) begin
          period_done = 1'b1;
          state_nx    = HIGH;
          hc_nx       = CNT_W'(1);
          pc_nx       = CNT_W'(1);
        end else begin
          pc_nx = sat_inc(pc);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (to_evt) begin
      state_nx = IDLE;
      hc_nx    = '0;
      pc_nx    = '0;
    end
  end

  // ---------------------------------------------------------------- divider
  // Dividend is hc followed by DUTY_W zero bits. The remainder starts at hc
  // (the top CNT_W dividend bits) and each step shifts in one zero bit.
  // hc >= pc means the quotient cannot fit in DUTY_W bits.
  logic              div_busy;
  logic [STEP_W-1:0] div_step;
  logic [CNT_W:0]    div_rem, rem_sh, rem_nx;
  logic [CNT_W-1:0]  div_dvs, div_hc;
  logic [DUTY_W-1:0] div_quo, quo_nx;
  logic              div_sat, rem_ge;
  logic              div_start, div_done, ovr_evt;

  assign div_start = period_done & ~div_busy;
  assign ovr_evt   = period_done & div_busy;
  assign div_done  = div_busy && (div_step == STEP_W'(DUTY_W - 1));

  assign rem_sh = {div_rem[CNT_W-1:0], 1'b0};
  assign rem_ge = rem_sh >= {1'b0, div_dvs};
  assign rem_nx = rem_ge ? rem_sh - {1'b0, div_dvs} : rem_sh;
  assign quo_nx = (div_quo << 1) | DUTY_W'(rem_ge);

  // Divider control; a timeout aborts an in-flight division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy <= 1'b0;
      div_step <= '0;
    end else if (to_evt) begin
      div_busy <= 1'b0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      div_step <= '0;
    end else if (div_done) begin
      div_busy <= 1'b0;
    end else if (div_busy) begin
      div_step <= div_step + STEP_W'(1);
    end
  end

  // Divider operands and one restoring step per cycle.
  always_ff @(posedge clk) begin
    if (div_start) begin
      div_rem <= {1'b0, hc};
      div_dvs <= pc;
      div_hc  <= hc;
      div_quo <= '0;
      div_sat <= (hc >= pc);
    end else if (div_busy) begin
      div_rem <= rem_nx;
      div_quo <= quo_nx;
    end
  end

  // ---------------------------------------------------------------- results
  logic [DUTY_W-1:0] duty_q;
  logic [CNT_W-1:0]  high_q, period_q;
  logic              valid_q, overrun_q;

  // Result registers; a timeout takes priority over a divider completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q    <= '0;
      high_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (ovr_evt) overrun_q <= 1'b1;
      if (to_evt) begin
        valid_q   <= 1'b1;
        timeout_q <= 1'b1;
        duty_q    <= {DUTY_W{lvl}};
        high_q    <= lvl ? TO_LIM : '0;
        period_q  <= '0;
      end else begin
        if (rise) timeout_q <= 1'b0;
        if (div_done) begin
          valid_q  <= 1'b1;
          duty_q   <= sat_quo(div_sat, quo_nx);
          high_q   <= div_hc;
          period_q <= div_dvs;
        end
      end
    end
  end

  assign bus.duty       = duty_q;
  assign bus.high_cnt   = high_q;
  assign bus.period_cnt = period_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder: directed and random PWM waveforms, an
// edge-timestamp reference model feeding a scoreboard queue, and a monitor
// that pops one expectation per valid pulse.
module tb_pwm_duty_decoder;
  localparam int CNT_W   = 16;
  localparam int DUTY_W  = 4;
  localparam int TIMEOUT = 64;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam int MINW = 3;
`else
  localparam int LAT  = 3;
  localparam int MINW = 1;
`endif
  localparam int DMAX = (1 << DUTY_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_duty_decoder_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) bus ();

  pwm_duty_decoder #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    longint duty;
    longint high;
    longint per;
    longint to;
    longint at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: works on input edge timestamps (cycle numbers at
  // which the bench changed the clean level).
  int prev_lvl, last_edge, last_rise, last_fall, busy_until;
  bit timed_out, ovr_exp;

  task automatic model_reset(input int m);
    prev_lvl   = 0;
    last_edge  = m;
    last_rise  = -1;
    last_fall  = -1;
    busy_until = -1000;
    timed_out  = 0;
    ovr_exp    = 0;
  endtask

  task automatic model_step(input int m, input int l);
    exp_t e;
    longint hi, pe, q;
    if (l != prev_lvl) begin
      last_edge = m;
      if (l == 1) begin
        timed_out = 0;
        if (last_rise >= 0 && last_fall > last_rise) begin
          hi = last_fall - last_rise;
          pe = m - last_rise;
          if (m > busy_until) begin
            q = (hi * (1 << DUTY_W)) / pe;
            e.duty = (q > DMAX) ? DMAX : q;
            e.high = hi;
            e.per  = pe;
            e.to   = 0;
            e.at   = m + DUTY_W + LAT;
            sb.push_back(e);
            busy_until = m + DUTY_W;
          end else begin
            ovr_exp = 1;
          end
        end
        last_rise = m;
      end else begin
        last_fall = m;
      end
    end else if (!timed_out && (m - last_edge) == TIMEOUT) begin
      timed_out = 1;
      while (sb.size() > 0 && sb[$].at > m + LAT) void'(sb.pop_back());
      e.duty = (l == 1) ? DMAX : 0;
      e.high = (l == 1) ? TIMEOUT : 0;
      e.per  = 0;
      e.to   = 1;
      e.at   = m + LAT;
      sb.push_back(e);
      last_rise  = -1;
      busy_until = -1000;
    end
    prev_lvl = l;
  endtask

  // Drive one cycle: d goes to the pin, m is the clean level the model sees.
  task automatic drv(input bit d, input bit m);
    @(posedge clk);
    #1;
    bus.pwm_in = d;
    model_step(cyc, int'(m));
  endtask

  task automatic hold(input bit l, input int n);
    for (int i = 0; i < n; i++) drv(l, l);
  endtask

  task automatic period(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  // Monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual duty=%0d high=%0d period=%0d required no valid (cycle %0d)",
                 bus.duty, bus.high_cnt, bus.period_cnt, cyc);
      end else begin
        e = sb.pop_front();
        chk("duty", bus.duty, e.duty);
        chk("high_cnt", bus.high_cnt, e.high);
        chk("period_cnt", bus.period_cnt, e.per);
        chk("timeout_at_valid", bus.timeout, e.to);
        chk("valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_duty"}, bus.duty, 0);
    chk({tag, "_high"}, bus.high_cnt, 0);
    chk({tag, "_period"}, bus.period_cnt, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    model_reset(cyc);

    // High 12 / low 4 -> duty 12
    repeat (6) period(12, 4);
    hold(1'b1, 3);
    chk("overrun_clean", bus.overrun, ovr_exp);
    hold(1'b0, 1);

    // High 5 / period 20 -> duty 4
    repeat (4) period(5, 15);

    // Stuck low -> timeout with duty 0; rise clears it without a valid
    hold(1'b0, TIMEOUT + 10);
    hold(1'b1, 6);
    chk("timeout_cleared", bus.timeout, 0);
    hold(1'b0, 6);
    repeat (2) period(6, 6);

    // Stuck high -> timeout with full duty and high_cnt = TIMEOUT
    hold(1'b1, TIMEOUT + 10);
    chk("timeout_high_level", bus.timeout, 1);
    repeat (3) period(3, 7);

    // Random waveforms
    repeat (25) period(int'($urandom_range(MINW, 30)), int'($urandom_range(MINW, 30)));
    hold(1'b0, 10);
    chk("overrun_random", bus.overrun, ovr_exp);

`ifdef PWM_DEC_GLITCH_FILTER_EN
    // 2-cycle glitch in the low phase must be invisible
    repeat (4) begin
      hold(1'b1, 8);
      hold(1'b0, 3);
      drv(1'b1, 1'b0);
      drv(1'b1, 1'b0);
      hold(1'b0, 3);
    end
    hold(1'b0, 10);
`else
    // Period 3 -> overrun, sticky; accepted results still correct (duty 5)
    repeat (10) period(1, 2);
    hold(1'b0, 6);
    chk("overrun_set", bus.overrun, ovr_exp);
    repeat (3) period(8, 8);
    chk("overrun_sticky", bus.overrun, ovr_exp);
`endif

    // Reset in the middle of a HIGH phase with a division in flight
    hold(1'b1, 6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    #1;
    chk_zero("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset(cyc);
    repeat (4) period(8, 8);
    hold(1'b0, 20);
    chk("overrun_after_rst", bus.overrun, ovr_exp);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
Receives a PWM waveform and recovers its duty code. It is the receive-side counterpart of the team's PWM generator and is used to close loops and self-check PWM outputs.
- Measures high time and period, rising edge to rising edge, in clk cycles.
- Computes duty = floor(high*2^DUTY_W/period) with a sequential divider.
- Reports stuck-high and stuck-low inputs through a timeout.

Parameters:
CNT_W, 16, width of the high/period counters in clk cycles
DUTY_W, 4, width of the recovered duty code (16 steps by default)
TIMEOUT, 1024, clk cycles without any input edge before timeout is declared (must be < 2^CNT_W)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high; clock clk
pwm_in  input  1  PWM input, asynchronous to clk
duty  output  DUTY_W  last recovered duty code
high_cnt  output  CNT_W  last measured high time, in cycles
period_cnt  output  CNT_W  last measured period, in cycles
valid  output  1  one-cycle pulse when duty/high_cnt/period_cnt update
timeout  output  1  level; input has had no edge for TIMEOUT cycles
overrun  output  1  sticky; a period completed while the divider was busy

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, counters 0, divider idle.
  - Synchronizer flops 0.
- Input path:
  - 2-flop synchronizer s1->s2, then a history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - All counting uses s2.
- FSM states IDLE, HIGH, LOW:
  - IDLE: wait for rise, then go to HIGH with hc=1, pc=1.
  - HIGH: hc++ and pc++ each cycle; on fall go to LOW (pc++).
  - LOW: pc++ each cycle; on rise the period completes:
    - latch hc and pc into the divider operands;
    - start the divider;
    - restart with hc=1, pc=1 and stay in HIGH.
  - A rise seen in HIGH cannot occur.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Divider:
  - Restoring divider, one quotient bit per cycle, DUTY_W cycles.
  - Dividend = hc << DUTY_W, held at CNT_W+DUTY_W bits.
  - Quotient saturates to 2^DUTY_W-1.
  - On completion, next cycle: duty, high_cnt and period_cnt update together, and valid=1 for exactly one cycle.
- Latency: valid asserts DUTY_W+1 cycles after the cycle in which the closing rise is detected.
- Overrun:
  - If a period completes while the divider is busy, that measurement is dropped and overrun is set (sticky until rst).
  - The in-flight division completes normally.
  - Guaranteed no-overrun when period >= DUTY_W+2 cycles.
- Timeout:
  - An idle counter clears on any rise or fall.
  - When it reaches TIMEOUT, the FSM goes to IDLE, timeout=1 and valid pulses once. Outputs by level:
    - s2=0: duty=0, high_cnt=0.
    - s2=1: duty=2^DUTY_W-1, high_cnt=TIMEOUT.
    - period_cnt=0 in both cases.
  - Any in-flight division is aborted and its result discarded.
  - timeout clears on the next rise, with no valid pulse. The first full period afterwards produces a normal valid.
- Reset mid-operation: asynchronous return to reset values. No valid pulse for the partial measurement.
- If valid is generated by a timeout and a divider completion in the same cycle, the timeout wins.

Optional Feature:
PWM_DEC_GLITCH_FILTER_EN
- Defined:
  - A filtered level f replaces s2 for edge detection and counting.
  - f changes only after s2 has held the new value for 3 consecutive cycles.
  - Pulses of 1-2 cycles are ignored.
  - Adds 2 cycles of latency to every edge; measured widths are unchanged for clean input.
- Not defined: s2 is used directly; no filtering logic is present.

Test Plan:
1. DUTY_W=4; input high 12 / low 4, repeated -> from the second rise onward: high_cnt=12, period_cnt=16, duty=12, one valid per period, overrun=0.
2. High 5 / period 20 -> duty=4 (floor 80/20), high_cnt=5, period_cnt=20.
3. Input held 0 for TIMEOUT cycles after activity -> timeout=1, duty=0, single valid pulse. Then a rise followed by a normal period -> timeout=0, and valid only after that period completes.
4. Input held 1 for TIMEOUT cycles -> timeout=1, duty=15, high_cnt=TIMEOUT.
5. Period 3 (high 1 / low 2) -> overrun=1, and it stays set. Still-valid results carry high_cnt=1, period_cnt=3, duty=5.
6. rst pulsed in the middle of a HIGH phase -> all outputs 0 immediately, no valid. With PWM_DEC_GLITCH_FILTER_EN, a 2-cycle glitch inside a low phase does not change period_cnt.
